// File: rtl/fifo_pkg.sv
// Shared definitions for the asynchronous FIFO blocks.
package fifo_pkg;

    localparam int FIFO_DATA_WIDTH = 8;
    localparam int FIFO_ADDR_WIDTH = 4;

    // Width of an occupancy counter that must represent 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_fwft_read_stage.sv
// Read-domain output stage: issues RAM reads when space is reserved and
// presents returned words as a first-word-fall-through valid/ready stream.
// OUT_DEPTH must be a power of two, at least 4, so the indices wrap for free.
module fifo_fwft_read_stage
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int OUT_DEPTH  = 4
) (
    input  logic                                r_clk,
    input  logic                                r_reset,
    input  logic                                r_empty,
    input  logic [DATA_WIDTH-1:0]               r_rdata,
    output logic                                r_inc,
    output logic                                m_valid,
    input  logic                                m_ready,
    output logic [DATA_WIDTH-1:0]               m_data,
    output logic [count_width(OUT_DEPTH)-1:0]   buf_count
);

    localparam int IDX_W = $clog2(OUT_DEPTH);
    localparam int CNT_W = count_width(OUT_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [OUT_DEPTH];
    logic [IDX_W-1:0]      wr_idx_q, wr_idx_d;
    logic [IDX_W-1:0]      rd_idx_q, rd_idx_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  pend_q;

    logic [CNT_W-1:0]      outstanding;
    logic                  pop;

    // count + pend_q never exceeds OUT_DEPTH, so it fits in CNT_W bits.
    assign outstanding = count_q + CNT_W'(pend_q);

    // Issue only when a slot is reserved for the word; never looks at m_ready.
    // Held low during reset so no request is raised while both sides restart.
    assign r_inc = !r_reset && !r_empty && (outstanding < CNT_W'(OUT_DEPTH));

    assign m_valid   = (count_q != '0);
    assign m_data    = mem_q[rd_idx_q];
    assign buf_count = count_q;
    assign pop       = m_valid && m_ready;

    // Next-state for indices and occupancy from capture (pend_q) and pop.
    always_comb begin
        wr_idx_d = wr_idx_q;
        rd_idx_d = rd_idx_q;
        count_d  = count_q;
        if (pend_q) begin
            wr_idx_d = wr_idx_q + IDX_W'(1);
        end
        if (pop) begin
            rd_idx_d = rd_idx_q + IDX_W'(1);
        end
        case ({pend_q, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control registers; reset discards buffered and in-flight words.
    always_ff @(posedge r_clk) begin
        if (r_reset) begin
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            count_q  <= '0;
            pend_q   <= 1'b0;
        end else begin
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
            count_q  <= count_d;
            pend_q   <= r_inc;
        end
    end

    // Ring-buffer storage; contents are don't-care after reset.
    always_ff @(posedge r_clk) begin
        if (pend_q && !r_reset) begin
            mem_q[wr_idx_q] <= r_rdata;
        end
    end

endmodule

// File: tb/tb_fifo_fwft_read_stage.sv
// Bench for fifo_fwft_read_stage: a fake pointer block/RAM feeds words and a
// queue-based model predicts the output stream and flow-control signals.
module tb_fifo_fwft_read_stage;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       r_reset;
    logic       r_empty;
    logic [7:0] r_rdata;
    logic       r_inc;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic [2:0] buf_count;

    int passed = 0;
    int total  = 0;

    // Model: src_q = words waiting in the pointer block, out_q = words issued
    // and not yet consumed (the newest is still in flight when pend_m is set).
    logic [7:0] src_q[$];
    logic [7:0] out_q[$];
    bit         pend_m = 1'b0;
    logic [7:0] pend_word = 8'h00;
    bit         exp_inc, exp_valid, cur_rst, cur_rdy;
    int         exp_count;
    logic [7:0] exp_data;

    always #5 clk = ~clk;

    fifo_fwft_read_stage #(.DATA_WIDTH(8), .OUT_DEPTH(DEPTH)) dut (
        .r_clk     (clk),
        .r_reset   (r_reset),
        .r_empty   (r_empty),
        .r_rdata   (r_rdata),
        .r_inc     (r_inc),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .buf_count (buf_count)
    );

    // Drive one cycle's inputs after the falling edge and compute expectations.
    task automatic drive(input bit rst, input bit rdy);
        @(negedge clk);
        cur_rst   = rst;
        cur_rdy   = rdy;
        r_reset   = rst;
        m_ready   = rdy;
        r_empty   = (src_q.size() == 0);
        r_rdata   = pend_m ? pend_word : 8'($urandom);
        exp_count = out_q.size() - (pend_m ? 1 : 0);
        exp_valid = (exp_count > 0);
        exp_data  = exp_valid ? out_q[0] : 8'h00;
        exp_inc   = !rst && (src_q.size() > 0) && (out_q.size() < DEPTH);
        #1;
    endtask

    // Cross the rising edge and advance the model.
    task automatic advance();
        logic [7:0] w;
        @(posedge clk);
        if (cur_rst) begin
            out_q.delete();
            pend_m = 1'b0;
        end else begin
            if (exp_valid && cur_rdy) void'(out_q.pop_front());
            if (exp_inc) begin
                w = src_q.pop_front();
                out_q.push_back(w);
                pend_word = w;
            end
            pend_m = exp_inc;
        end
    endtask

    task automatic restart();
        drive(1'b1, 1'b0);
        advance();
        src_q.delete();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) src_q.push_back(8'h10 + 8'(i));
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1);
            total++;
            if (r_inc !== 1'b0) $display("FAIL reset_inc: got %0b want 0", r_inc);
            else passed++;
            advance();
        end
        drive(1'b0, 1'b1);
        total++;
        if (m_valid !== 1'b0 || buf_count !== 3'd0 || r_inc !== 1'b1)
            $display("FAIL reset_state: got valid=%0b count=%0d inc=%0b want 0 0 1",
                     m_valid, buf_count, r_inc);
        else passed++;
        advance();
        for (int c = 0; c < 6; c++) begin
            drive(1'b0, 1'b1);
            total++;
            if (m_valid !== exp_valid || (exp_valid && m_data !== exp_data))
                $display("FAIL reset_drain: got valid=%0b data=%h want %0b %h",
                         m_valid, m_data, exp_valid, exp_data);
            else passed++;
            advance();
        end
    endtask

    task automatic test_latency();
        int n = -1;
        restart();
        for (int c = 0; c < 2; c++) begin
            drive(1'b0, 1'b1);
            total++;
            if (r_inc !== 1'b0 || m_valid !== 1'b0)
                $display("FAIL lat_idle: got inc=%0b valid=%0b want 0 0", r_inc, m_valid);
            else passed++;
            advance();
        end
        src_q.push_back(8'hA5);
        for (int c = 0; c < 6; c++) begin
            drive(1'b0, 1'b1);
            if (r_inc === 1'b1 && n < 0) n = c;
            if (n >= 0 && (c == n + 1 || c == n + 3)) begin
                total++;
                if (m_valid !== 1'b0) $display("FAIL lat_gap c=%0d: got valid=%0b want 0", c, m_valid);
                else passed++;
            end
            if (n >= 0 && c == n + 2) begin
                total++;
                if (m_valid !== 1'b1 || m_data !== 8'hA5)
                    $display("FAIL lat_word: got valid=%0b data=%h want 1 a5", m_valid, m_data);
                else passed++;
            end
            advance();
        end
        total++;
        if (n !== 0) $display("FAIL lat_issue_cycle: got %0d want 0", n);
        else passed++;
    endtask

    task automatic test_streaming();
        int pops = 0;
        restart();
        for (int i = 0; i < 20; i++) src_q.push_back(8'(i));
        for (int c = 0; c < 24; c++) begin
            drive(1'b0, 1'b1);
            if (c < 20) begin
                total++;
                if (r_inc !== 1'b1) $display("FAIL stream_inc c=%0d: got %0b want 1", c, r_inc);
                else passed++;
            end
            total++;
            if (c >= 2 && c < 22) begin
                if (m_valid !== 1'b1 || m_data !== 8'(c - 2))
                    $display("FAIL stream_word c=%0d: got valid=%0b data=%h want 1 %h",
                             c, m_valid, m_data, 8'(c - 2));
                else passed++;
            end else begin
                if (m_valid !== 1'b0) $display("FAIL stream_idle c=%0d: got valid=%0b want 0", c, m_valid);
                else passed++;
            end
            if (m_valid === 1'b1) pops++;
            advance();
        end
        total++;
        if (pops !== 20) $display("FAIL stream_total: got %0d want 20", pops);
        else passed++;
    endtask

    task automatic test_backpressure();
        int pulses = 0;
        int pops = 0;
        restart();
        for (int i = 0; i < 16; i++) src_q.push_back(8'h40 + 8'(i));
        for (int c = 0; c < 8; c++) begin
            drive(1'b0, 1'b0);
            if (r_inc === 1'b1) pulses++;
            advance();
        end
        total++;
        if (pulses !== 4) $display("FAIL bp_pulses: got %0d want 4", pulses);
        else passed++;
        drive(1'b0, 1'b0);
        total++;
        if (buf_count !== 3'd4 || r_inc !== 1'b0)
            $display("FAIL bp_full: got count=%0d inc=%0b want 4 0", buf_count, r_inc);
        else passed++;
        advance();
        for (int c = 0; c < 18; c++) begin
            drive(1'b0, 1'b1);
            total++;
            if (r_inc !== exp_inc || m_valid !== exp_valid ||
                (exp_valid && m_data !== 8'h40 + 8'(pops)))
                $display("FAIL bp_drain c=%0d: got inc=%0b valid=%0b data=%h want %0b %0b %h",
                         c, r_inc, m_valid, m_data, exp_inc, exp_valid, 8'h40 + 8'(pops));
            else passed++;
            if (m_valid === 1'b1) pops++;
            advance();
        end
        total++;
        if (pops !== 16) $display("FAIL bp_total: got %0d want 16", pops);
        else passed++;
    endtask

    task automatic test_simultaneous();
        bit rdy_pat[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        restart();
        for (int i = 0; i < 8; i++) src_q.push_back(8'h60 + 8'(i));
        for (int c = 0; c < 6; c++) begin
            drive(1'b0, rdy_pat[c]);
            if (c == 3 || c == 4) begin
                total++;
                if (buf_count !== 3'd2) $display("FAIL sim_count c=%0d: got %0d want 2", c, buf_count);
                else passed++;
            end
            if (c == 4) begin
                total++;
                if (m_data !== 8'h61) $display("FAIL sim_order: got %h want 61", m_data);
                else passed++;
            end
            if (c == 5) begin
                total++;
                if (buf_count !== 3'd3 || r_inc !== 1'b0)
                    $display("FAIL sim_reserve: got count=%0d inc=%0b want 3 0", buf_count, r_inc);
                else passed++;
            end
            advance();
        end
        for (int c = 0; c < 10; c++) begin
            drive(1'b0, 1'b1);
            total++;
            if (m_valid !== exp_valid || (exp_valid && m_data !== exp_data))
                $display("FAIL sim_tail c=%0d: got valid=%0b data=%h want %0b %h",
                         c, m_valid, m_data, exp_valid, exp_data);
            else passed++;
            advance();
        end
    endtask

    task automatic test_mid_reset();
        restart();
        for (int i = 0; i < 8; i++) src_q.push_back(8'h80 + 8'(i));
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, 1'b0);
            advance();
        end
        drive(1'b1, 1'b1);
        total++;
        if (buf_count !== 3'd3) $display("FAIL mr_pre: got count=%0d want 3", buf_count);
        else passed++;
        advance();
        src_q.delete();
        drive(1'b0, 1'b1);
        total++;
        if (m_valid !== 1'b0 || buf_count !== 3'd0 || r_inc !== 1'b0)
            $display("FAIL mr_post: got valid=%0b count=%0d inc=%0b want 0 0 0",
                     m_valid, buf_count, r_inc);
        else passed++;
        advance();
        for (int i = 0; i < 4; i++) src_q.push_back(8'hC0 + 8'(i));
        for (int c = 0; c < 8; c++) begin
            drive(1'b0, 1'b1);
            total++;
            if (m_valid !== exp_valid || (m_valid === 1'b1 && m_data !== exp_data))
                $display("FAIL mr_fresh c=%0d: got valid=%0b data=%h want %0b %h",
                         c, m_valid, m_data, exp_valid, exp_data);
            else passed++;
            advance();
        end
    endtask

    task automatic test_random();
        logic [7:0] seq = 8'h00;
        restart();
        for (int c = 0; c < 400; c++) begin
            if (src_q.size() < 6 && $urandom_range(0, 2) != 0) begin
                src_q.push_back(seq);
                seq++;
            end
            drive(1'b0, 1'($urandom_range(0, 3) != 0));
            total++;
            if (r_inc !== exp_inc || m_valid !== exp_valid ||
                buf_count !== 3'(exp_count) || (exp_valid && m_data !== exp_data))
                $display("FAIL rand c=%0d: got inc=%0b valid=%0b count=%0d data=%h want %0b %0b %0d %h",
                         c, r_inc, m_valid, buf_count, m_data,
                         exp_inc, exp_valid, exp_count, exp_data);
            else passed++;
            advance();
        end
    endtask

    initial begin
        r_reset = 1'b1;
        r_empty = 1'b1;
        r_rdata = 8'h00;
        m_ready = 1'b0;
        test_reset();
        test_latency();
        test_streaming();
        test_backpressure();
        test_simultaneous();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
